// File: rtl/baud_pkg.sv
// Shared types and elaboration helpers for the UART baud tick scheduler.
package baud_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/baud_phase_ctr.sv
// Per-channel IDLE/RUN FSM with an oversample phase counter and a registered bit strobe.
module baud_phase_ctr
  import baud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PRELOAD    = 0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_req,
  input  logic i_os_tick,
  output logic o_tick,
  output logic o_active
);

  localparam int unsigned PW = clog2_u(OVERSAMPLE);
  localparam logic [PW-1:0] PHASE_PRE  = PW'(PRELOAD);
  localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);

  chan_state_e   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          state_d = ST_RUN;
          phase_d = PHASE_PRE;
        end
      end
      ST_RUN: begin
        // Dropping req wins over a coinciding strobe.
        if (!i_req) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (i_os_tick) begin
          phase_d = phase_q + PW'(1);
          tick_d  = (phase_q == PHASE_LAST);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick   = tick_q;
  assign o_active = (state_q == ST_RUN);

endmodule

// File: rtl/baud_tick_sched.sv
// Shared oversampling baud divider feeding independent TX (bit-edge) and RX (mid-bit) strobes.
module baud_tick_sched
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tx_req,
  input  logic i_rx_req,
  output logic o_os_tick,
  output logic o_tx_tick,
  output logic o_rx_tick,
  output logic o_tx_active,
  output logic o_rx_active,
  output logic o_busy
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam logic [31:0] DIV_LAST = 32'(DIVISOR - 1);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("baud_tick_sched: DIVISOR must be at least 2");
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
    $error("baud_tick_sched: OVERSAMPLE must be a power of two and at least 4");
  end

  logic        div_en;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        os_tick_q, os_tick_d;

  assign div_en = i_tx_req | i_rx_req;

  // Counter is held at zero while idle so a fresh start has a fixed latency.
  always_comb begin
    div_cnt_d = '0;
    os_tick_d = 1'b0;
    if (div_en) begin
      if (div_cnt_q == DIV_LAST) begin
        os_tick_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt_q <= '0;
      os_tick_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      os_tick_q <= os_tick_d;
    end
  end

  baud_phase_ctr #(
    .OVERSAMPLE (OVERSAMPLE),
    .PRELOAD    (0)
  ) u_tx_phase (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_tx_req),
    .i_os_tick (os_tick_q),
    .o_tick    (o_tx_tick),
    .o_active  (o_tx_active)
  );

  baud_phase_ctr #(
    .OVERSAMPLE (OVERSAMPLE),
    .PRELOAD    (OVERSAMPLE / 2)
  ) u_rx_phase (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_rx_req),
    .i_os_tick (os_tick_q),
    .o_tick    (o_rx_tick),
    .o_active  (o_rx_active)
  );

  assign o_os_tick = os_tick_q;
  assign o_busy    = o_tx_active | o_rx_active;

endmodule

// File: tb/tb_baud_tick_sched.sv
// Directed bench for baud_tick_sched with DIVISOR=10, OVERSAMPLE=16.
module tb_baud_tick_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_req = 1'b0;
  logic rx_req = 1'b0;
  logic os_tick, tx_tick, rx_tick, tx_active, rx_active, busy;

  int total = 0;
  int bad = 0;

  baud_tick_sched #(
    .CLK_FREQ   (1600),
    .BAUD_RATE  (10),
    .OVERSAMPLE (16)
  ) u_dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_tx_req    (tx_req),
    .i_rx_req    (rx_req),
    .o_os_tick   (os_tick),
    .o_tx_tick   (tx_tick),
    .o_rx_tick   (rx_tick),
    .o_tx_active (tx_active),
    .o_rx_active (rx_active),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    tx_req = 1'b0;
    rx_req = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    int errs = 0;
    int first = -1;
    #12;
    outs = {os_tick, tx_tick, rx_tick, tx_active, rx_active, busy};
    total++;
    if (outs !== 6'b0) begin
      bad++;
      $display("FAIL reset_init: outputs=%b want 000000", outs);
    end
    #5 rst_n = 1'b1;
    step();
    // Run both channels until the first RX strobe, then reset between edges.
    tx_req = 1'b1;
    rx_req = 1'b1;
    for (int e = 0; e <= 80; e++) step();
    total++;
    if (rx_tick !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_prerun: rx_tick=%b busy=%b want 1 1", rx_tick, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {os_tick, tx_tick, rx_tick, tx_active, rx_active, busy};
    total++;
    if (outs !== 6'b0) begin
      bad++;
      $display("FAIL reset_async: outputs=%b want 000000", outs);
    end
    tx_req = 1'b0;
    rx_req = 1'b0;
    #2 rst_n = 1'b1;
    for (int e = 0; e < 500; e++) begin
      step();
      outs = {os_tick, tx_tick, rx_tick, tx_active, rx_active, busy};
      if (outs !== 6'b0) begin
        if (errs == 0) first = e;
        errs++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL reset_quiet: %0d edges with activity, first at %0d, want none", errs, first);
    end
  endtask

  task automatic test_tx_only();
    int err_os = 0, err_tx = 0, err_misc = 0, n_tx = 0, consec = 0;
    int first_os = -1, first_tx = -1;
    logic prev_tx = 1'b0;
    go_idle();
    tx_req = 1'b1;
    for (int e = 0; e < 500; e++) begin
      step();
      if (os_tick !== (e % 10 == 9)) begin
        if (err_os == 0) first_os = e;
        err_os++;
      end
      if (tx_tick !== (e >= 160 && e % 160 == 0)) begin
        if (err_tx == 0) first_tx = e;
        err_tx++;
      end
      if (tx_active !== 1'b1 || rx_active !== 1'b0 || rx_tick !== 1'b0 || busy !== 1'b1)
        err_misc++;
      if (tx_tick === 1'b1) n_tx++;
      if (tx_tick === 1'b1 && prev_tx === 1'b1) consec++;
      prev_tx = tx_tick;
    end
    total++;
    if (err_os !== 0) begin
      bad++;
      $display("FAIL tx_os_tick: %0d wrong edges, first E%0d, want high after E9,E19,...", err_os,
               first_os);
    end
    total++;
    if (err_tx !== 0) begin
      bad++;
      $display("FAIL tx_tick: %0d wrong edges, first E%0d, want high after E160,E320,E480",
               err_tx, first_tx);
    end
    total++;
    if (n_tx !== 3 || consec !== 0) begin
      bad++;
      $display("FAIL tx_count: ticks=%0d consecutive=%0d want 3 and 0", n_tx, consec);
    end
    total++;
    if (err_misc !== 0) begin
      bad++;
      $display("FAIL tx_status: %0d edges with wrong active/busy/rx_tick, want 0", err_misc);
    end
    tx_req = 1'b0;
    step();
    total++;
    if (tx_active !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tx_fall: tx_active=%b busy=%b want 0 0", tx_active, busy);
    end
  endtask

  task automatic test_rx_only();
    int err_rx = 0, err_os = 0, first_rx = -1;
    go_idle();
    rx_req = 1'b1;
    for (int e = 0; e < 420; e++) begin
      step();
      if (rx_tick !== (e >= 80 && (e - 80) % 160 == 0) || tx_tick !== 1'b0) begin
        if (err_rx == 0) first_rx = e;
        err_rx++;
      end
      if (os_tick !== (e % 10 == 9) || rx_active !== 1'b1) err_os++;
    end
    total++;
    if (err_rx !== 0) begin
      bad++;
      $display("FAIL rx_tick: %0d wrong edges, first E%0d, want high after E80,E240,E400",
               err_rx, first_rx);
    end
    total++;
    if (err_os !== 0) begin
      bad++;
      $display("FAIL rx_os_active: %0d wrong edges, want 0", err_os);
    end
  endtask

  task automatic test_shared();
    int err_tx = 0, err_rx = 0, err_os = 0, err_act = 0, first_rx = -1;
    go_idle();
    tx_req = 1'b1;
    for (int e = 0; e < 330; e++) begin
      if (e == 45) rx_req = 1'b1;
      step();
      if (os_tick !== (e % 10 == 9)) err_os++;
      if (tx_tick !== (e >= 160 && e % 160 == 0)) err_tx++;
      // RX joins at phase 8 and needs eight more oversample ticks: E50..E120.
      if (rx_tick !== (e >= 120 && (e - 120) % 160 == 0)) begin
        if (err_rx == 0) first_rx = e;
        err_rx++;
      end
      if (rx_active !== (e >= 45)) err_act++;
    end
    total++;
    if (err_os !== 0) begin
      bad++;
      $display("FAIL shared_os: %0d edges where divider phase was disturbed, want 0", err_os);
    end
    total++;
    if (err_tx !== 0) begin
      bad++;
      $display("FAIL shared_tx: %0d wrong edges, want tx ticks after E160,E320 only", err_tx);
    end
    total++;
    if (err_rx !== 0) begin
      bad++;
      $display("FAIL shared_rx: %0d wrong edges, first E%0d, want rx ticks after E120,E280",
               err_rx, first_rx);
    end
    total++;
    if (err_act !== 0) begin
      bad++;
      $display("FAIL shared_rx_active: %0d wrong edges, want rise after E45", err_act);
    end
  endtask

  task automatic test_stop_coincide();
    int err_tx = 0, err_os = 0, err_cnt = 0, err_act = 0;
    go_idle();
    tx_req = 1'b1;
    for (int e = 0; e < 200; e++) begin
      if (e == 160) tx_req = 1'b0;
      step();
      if (tx_tick !== 1'b0) err_tx++;
      if (os_tick !== (e < 160 && e % 10 == 9)) err_os++;
      if (e >= 160 && u_dut.div_cnt_q !== 32'd0) err_cnt++;
      if (tx_active !== (e < 160) || busy !== (e < 160)) err_act++;
    end
    total++;
    if (err_tx !== 0) begin
      bad++;
      $display("FAIL stop_tx_tick: %0d edges with tx_tick, want none", err_tx);
    end
    total++;
    if (err_os !== 0 || err_cnt !== 0) begin
      bad++;
      $display("FAIL stop_divider: os errors=%0d count errors=%0d want 0 0", err_os, err_cnt);
    end
    total++;
    if (err_act !== 0) begin
      bad++;
      $display("FAIL stop_active: %0d wrong edges, want fall after E160", err_act);
    end
  endtask

  task automatic test_rearm();
    int err_rx = 0, err_os = 0, err_act = 0, first_rx = -1;
    logic exp_os, exp_rx;
    go_idle();
    rx_req = 1'b1;
    for (int e = 0; e < 280; e++) begin
      if (e == 100) rx_req = 1'b0;
      if (e == 101) rx_req = 1'b1;
      step();
      // Re-arm at E101 restarts the idle divider, so the new origin is E101.
      if (e < 100) exp_os = (e % 10 == 9);
      else if (e == 100) exp_os = 1'b0;
      else exp_os = ((e - 101) % 10 == 9);
      exp_rx = (e == 80) || (e == 181);
      if (os_tick !== exp_os) err_os++;
      if (rx_tick !== exp_rx) begin
        if (err_rx == 0) first_rx = e;
        err_rx++;
      end
      if (rx_active !== (e != 100)) err_act++;
    end
    total++;
    if (err_rx !== 0) begin
      bad++;
      $display("FAIL rearm_rx: %0d wrong edges, first E%0d, want rx ticks after E80,E181",
               err_rx, first_rx);
    end
    total++;
    if (err_os !== 0) begin
      bad++;
      $display("FAIL rearm_os: %0d wrong edges, want 0", err_os);
    end
    total++;
    if (err_act !== 0) begin
      bad++;
      $display("FAIL rearm_active: %0d wrong edges, want low only after E100", err_act);
    end
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_rx_only();
    test_shared();
    test_stop_coincide();
    test_rearm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
